// File: rtl/led_bank_arbiter.sv
// Round-robin arbiter sharing the board LED bank among NREQ requesters,
// with bounded hold time, a one-cycle gap between owners, and a heartbeat blink.
`timescale 1ns/1ps
module led_bank_arbiter #(
    parameter int unsigned NREQ       = 3,
    parameter int unsigned LED_W      = 6,
    parameter int unsigned TICK_DIV   = 25000000,
    parameter int unsigned HOLD_TICKS = 4
) (
    input  logic                    clk50,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*LED_W-1:0]   pattern,
    output logic [NREQ-1:0]         grant,
    output logic [LED_W-1:0]        leds,
    output logic                    blink,
    output logic                    busy
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned HW = $clog2(HOLD_TICKS + 1);
    localparam int unsigned LW = $clog2(NREQ);

    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [LW-1:0] LAST_INIT = LW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    state_t              state, state_d;
    logic [PW-1:0]       prescaler;
    logic                tick;
    logic [HW-1:0]       hold_cnt, hold_d;
    logic [LW-1:0]       last, last_d;
    logic [LW-1:0]       winner, cand;
    logic                found;
    logic [NREQ-1:0]     grant_d;
    logic [LED_W-1:0]    leds_d;
    logic [LED_W-1:0]    slice [NREQ];

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            slice[i] = pattern[i*LED_W +: LED_W];
        end
    end

    always_comb tick = (prescaler == TICK_LAST);
    always_comb busy = (state != IDLE);

    // Search starts just after the last owner, so it ends up with lowest priority.
    always_comb begin
        winner = last;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = LW'((32'(last) + k) % NREQ);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state;
        grant_d = '0;
        leds_d  = '0;
        last_d  = last;
        hold_d  = hold_cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    state_d         = GRANT;
                    grant_d[winner] = 1'b1;
                    leds_d          = slice[winner];
                    last_d          = winner;
                    hold_d          = '0;
                end
            end
            GRANT: begin
                if (!req[last] || (tick && hold_cnt == HOLD_LAST)) begin
                    state_d = GAP;
                    hold_d  = '0;
                end else begin
                    grant_d = grant;
                    leds_d  = slice[last];
                    if (tick) begin
                        hold_d = hold_cnt + 1'b1;
                    end
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk50) begin
        if (rst) begin
            prescaler <= '0;
            blink     <= 1'b0;
            state     <= IDLE;
            grant     <= '0;
            leds      <= '0;
            last      <= LAST_INIT;
            hold_cnt  <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                blink <= ~blink;
            end
            state    <= state_d;
            grant    <= grant_d;
            leds     <= leds_d;
            last     <= last_d;
            hold_cnt <= hold_d;
        end
    end

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Scoreboard bench for led_bank_arbiter: stimulus queues cycle-stamped expectations,
// a monitor compares outputs 1 ns after each rising edge.
`timescale 1ns/1ps
module tb_led_bank_arbiter;

    localparam int END_CYC = 130;

    logic        clk50 = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [17:0] pattern;
    logic [2:0]  grant;
    logic [5:0]  leds;
    logic        blink;
    logic        busy;

    led_bank_arbiter #(
        .NREQ      (3),
        .LED_W     (6),
        .TICK_DIV  (4),
        .HOLD_TICKS(4)
    ) dut (
        .clk50  (clk50),
        .rst    (rst),
        .req    (req),
        .pattern(pattern),
        .grant  (grant),
        .leds   (leds),
        .blink  (blink),
        .busy   (busy)
    );

    always #5 clk50 = ~clk50;

    // cyc = number of rising edges seen so far
    int cyc = 0;
    always @(posedge clk50) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [10:0] exp;   // {grant, leds, busy, blink}
        logic [10:0] mask;
        string       name;
    } chk_t;

    chk_t sb[$];

    function automatic void push_out(input int c, input logic [2:0] g, input logic [5:0] l,
                                     input logic b, input string n);
        chk_t e;
        e.cyc  = c;
        e.exp  = {g, l, b, 1'b0};
        e.mask = 11'h7FE;
        e.name = n;
        sb.push_back(e);
    endfunction

    function automatic void push_full(input int c, input logic [2:0] g, input logic [5:0] l,
                                      input logic b, input logic bl, input string n);
        chk_t e;
        e.cyc  = c;
        e.exp  = {g, l, b, bl};
        e.mask = 11'h7FF;
        e.name = n;
        sb.push_back(e);
    endfunction

    function automatic void push_blink(input int c, input logic bl, input string n);
        chk_t e;
        e.cyc  = c;
        e.exp  = {10'b0, bl};
        e.mask = 11'h001;
        e.name = n;
        sb.push_back(e);
    endfunction

    task automatic at(input int n);
        while (cyc < n) @(negedge clk50);
    endtask

    // Monitor / checker
    int n_cmp = 0;
    int n_bad = 0;
    int n_hit = 0;
    logic [10:0] act;

    always @(posedge clk50) begin
        #1;
        act = {grant, leds, busy, blink};
        n_cmp++;
        if (!$onehot0(grant)) begin
            n_bad++;
            $display("FAIL onehot @cyc %0d: grant=%b, required one-hot or zero", cyc, grant);
        end
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc == cyc) begin
                n_hit++;
                n_cmp++;
                if ((act & sb[i].mask) !== (sb[i].exp & sb[i].mask)) begin
                    n_bad++;
                    $display("FAIL %s @cyc %0d: got {grant,leds,busy,blink}=%b required %b (mask %b)",
                             sb[i].name, cyc, act, sb[i].exp, sb[i].mask);
                end
            end
        end
        if (cyc == END_CYC) begin
            n_cmp++;
            if (n_hit != sb.size()) begin
                n_bad++;
                $display("FAIL unchecked: got %0d expectations checked, required %0d", n_hit, sb.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    initial begin
        #5000;
        $display("FAIL watchdog: simulation reached time limit before cycle %0d", END_CYC);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        req     = 3'b000;
        pattern = '0;

        // Reset release after edge 3; blink first toggles at edge 7, then every 4
        for (int c = 4; c <= 14; c++) begin
            push_full(c, 3'b000, 6'h00, 1'b0, 1'(((c - 3) / 4) % 2), "idle_reset");
        end
        at(3);
        rst = 1'b0;

        // Single requester, hold expiry, re-grant, live pattern change
        push_out(15, 3'b001, 6'h15, 1'b1, "single_grant");
        push_out(30, 3'b001, 6'h15, 1'b1, "single_hold_end");
        push_out(31, 3'b000, 6'h00, 1'b1, "single_gap");
        push_out(32, 3'b000, 6'h00, 1'b0, "single_idle");
        push_out(33, 3'b001, 6'h15, 1'b1, "single_regrant");
        push_out(36, 3'b001, 6'h15, 1'b1, "pat_before");
        push_out(37, 3'b001, 6'h2A, 1'b1, "pat_after");
        push_out(46, 3'b001, 6'h2A, 1'b1, "regrant_hold_end");
        push_out(47, 3'b000, 6'h00, 1'b1, "regrant_gap");
        at(14);
        req          = 3'b001;
        pattern[5:0] = 6'h15;
        at(36);
        pattern[5:0] = 6'h2A;

        // Full contention from last=0: 010, 100, 001, 010
        push_out(48, 3'b000, 6'h00, 1'b0, "rr_idle0");
        push_out(49, 3'b010, 6'h02, 1'b1, "rr_g1");
        push_out(62, 3'b010, 6'h02, 1'b1, "rr_g1_end");
        push_out(63, 3'b000, 6'h00, 1'b1, "rr_gap1");
        push_out(64, 3'b000, 6'h00, 1'b0, "rr_idle1");
        push_out(65, 3'b100, 6'h04, 1'b1, "rr_g2");
        push_out(78, 3'b100, 6'h04, 1'b1, "rr_g2_end");
        push_out(79, 3'b000, 6'h00, 1'b1, "rr_gap2");
        push_out(80, 3'b000, 6'h00, 1'b0, "rr_idle2");
        push_out(81, 3'b001, 6'h01, 1'b1, "rr_g0");
        push_out(94, 3'b001, 6'h01, 1'b1, "rr_g0_end");
        push_out(97, 3'b010, 6'h02, 1'b1, "rr_g1_again");
        at(47);
        req     = 3'b111;
        pattern = {6'h04, 6'h02, 6'h01};

        // Early release by requester 1, requester 2 next
        push_out(100, 3'b010, 6'h02, 1'b1, "early_owner");
        push_out(101, 3'b000, 6'h00, 1'b1, "early_gap");
        push_out(102, 3'b000, 6'h00, 1'b0, "early_idle");
        push_out(103, 3'b100, 6'h04, 1'b1, "early_next");
        at(100);
        req = 3'b101;

        // Reset while requester 2 owns; requester 0 wins afterwards
        push_out(106, 3'b100, 6'h04, 1'b1, "rst_owner");
        push_full(107, 3'b000, 6'h00, 1'b0, 1'b0, "rst_mid");
        push_full(108, 3'b000, 6'h00, 1'b0, 1'b0, "rst_hold");
        push_out(109, 3'b001, 6'h01, 1'b1, "rst_first_win");
        push_blink(111, 1'b0, "rst_blink_pre");
        push_blink(112, 1'b1, "rst_blink_toggle");
        push_out(123, 3'b001, 6'h01, 1'b1, "rst_hold_end");
        push_out(124, 3'b000, 6'h00, 1'b1, "rst_gap");
        push_out(125, 3'b000, 6'h00, 1'b0, "rst_idle");
        push_out(126, 3'b010, 6'h02, 1'b1, "rst_next");
        push_out(127, 3'b000, 6'h00, 1'b1, "release_gap");
        push_out(128, 3'b000, 6'h00, 1'b0, "release_idle");
        at(106);
        rst = 1'b1;
        req = 3'b111;
        at(108);
        rst = 1'b0;
        at(126);
        req = 3'b000;
    end

endmodule
